uart_bus_periph: RTL and testbench

Memory-mapped 8N1 UART that sits directly downstream of the CPU5_9 data bus and consumes its `Addr`/`Dout`/`write`/`read` strobes. It returns read data on the CPU's `Din` path and raises one level interrupt line that feeds one bit of the CPU's `Interrupts` input. Internally it holds an 8-entry TX FIFO and an 8-entry RX FIFO, a programmable baud divisor, and independent TX and RX serial state machines.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_bus_periph.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_bus_periph.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, status bit indices and FSM state types for the bus UART
package uart_pkg;

    // Register offsets within the 4-word window
    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RXOVR    = 4;
    localparam int ST_TX_BUSY  = 5;
    localparam int ST_FERR     = 6;
    localparam int ST_TXOVF    = 7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with head-of-queue output
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    // A pop frees a slot for a same-cycle push, and a same-cycle push feeds a pop from empty
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && (!empty || push);
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_bus_periph.sv
// rtl/uart_bus_periph.sv - memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor and level irq
module uart_bus_periph
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter logic [15:0] DIV_RESET  = 16'd433,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        write,
    input  logic        read,
    output logic [15:0] rdata,
    output logic        irq,
    input  logic        rx,
    output logic        tx
);

    logic        hit;
    logic [1:0]  off;
    logic        wr_data, rd_data, wr_status, wr_div, wr_ctrl;

    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  tx_head;
    logic        rx_full, rx_empty, rx_pop, rx_push, rx_ferr_set;
    logic [7:0]  rx_head;

    logic [15:0] div_q, div_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        rxovr_q, rxovr_d, ferr_q, ferr_d, txovf_q, txovf_d;
    logic        irq_q, irq_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    logic [7:0]  status;

    assign hit       = (addr[15:2] == BASE_ADDR[15:2]);
    assign off       = addr[1:0];
    assign wr_data   = write && hit && (off == UART_DATA);
    assign rd_data   = read  && hit && (off == UART_DATA);
    assign wr_status = write && hit && (off == UART_STATUS);
    assign wr_div    = write && hit && (off == UART_DIV);
    assign wr_ctrl   = write && hit && (off == UART_CTRL);
    assign rx_pop    = rd_data && !rx_empty;
    assign tx        = tx_q;
    assign irq       = irq_q;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk_bus),
        .rst_n     (rst_bus),
        .push      (wr_data),
        .push_data (wdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk_bus),
        .rst_n     (rst_bus),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Status word assembly and combinational read mux, zero unless a read hits
    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RXOVR]    = rxovr_q;
        status[ST_TX_BUSY]  = (tx_state_q != TX_IDLE);
        status[ST_FERR]     = ferr_q;
        status[ST_TXOVF]    = txovf_q;
        rdata = '0;
        if (read && hit) begin
            case (off)
                UART_DATA:   rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
                UART_STATUS: rdata = {8'h00, status};
                UART_DIV:    rdata = div_q;
                default:     rdata = {14'h0000, ctrl_q};
            endcase
        end
    end

    // Control registers, sticky flags (hardware set beats CPU clear), irq and rx synchronizer
    always_comb begin
        div_d     = wr_div  ? wdata : div_q;
        ctrl_d    = wr_ctrl ? wdata[1:0] : ctrl_q;
        txovf_d   = (txovf_q & ~(wr_status & wdata[ST_TXOVF]))
                  | (wr_data & tx_full & ~tx_pop);
        rxovr_d   = (rxovr_q & ~(wr_status & wdata[ST_RXOVR]))
                  | (rx_push & rx_full & ~rx_pop);
        ferr_d    = (ferr_q & ~(wr_status & wdata[ST_FERR])) | rx_ferr_set;
        irq_d     = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
    end

    // Transmit FSM: start, 8 data bits LSB first, stop; chains frames with no idle bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q != 16'd0) ? tx_cnt_q - 16'd1 : tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = div_q;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            default: begin
                if (tx_cnt_q == 16'd0) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = TX_START;
                        tx_cnt_d   = div_q;
                        tx_shift_d = tx_head;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
        endcase
    end

    // Receive FSM: mid-bit sampling after a synced falling edge, glitch and framing checks
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = (rx_cnt_q != 16'd0) ? rx_cnt_q - 16'd1 : rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = {1'b0, div_q[15:1]};
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = div_q;
                        rx_bit_d   = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        rx_push = 1'b1;
                    end else begin
                        rx_ferr_set = 1'b1;
                    end
                end
            end
        endcase
    end

    // State registers; reset idles the line and aborts any frame in flight
    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            div_q      <= DIV_RESET;
            ctrl_q     <= '0;
            rxovr_q    <= 1'b0;
            ferr_q     <= 1'b0;
            txovf_q    <= 1'b0;
            irq_q      <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            rxovr_q    <= rxovr_d;
            ferr_q     <= ferr_d;
            txovf_q    <= txovf_d;
            irq_q      <= irq_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_periph.sv
// tb/tb_uart_bus_periph.sv - randomized self-checking bench for the bus UART
module tb_uart_bus_periph;

    logic        clk_bus = 1'b0;
    logic        rst_bus;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic        read;
    logic [15:0] rdata;
    logic        irq;
    logic        tx;
    logic        rx;
    logic        rx_tb;
    logic        loop_en;

    localparam logic [15:0] A_DATA = 16'hFF00;
    localparam logic [15:0] A_STAT = 16'hFF01;
    localparam logic [15:0] A_DIV  = 16'hFF02;
    localparam logic [15:0] A_CTRL = 16'hFF03;

    int n_checks = 0;
    int n_fail   = 0;

    assign rx = loop_en ? tx : rx_tb;

    always #5 clk_bus = ~clk_bus;

    uart_bus_periph dut (
        .clk_bus (clk_bus),
        .rst_bus (rst_bus),
        .addr    (addr),
        .wdata   (wdata),
        .write   (write),
        .read    (read),
        .rdata   (rdata),
        .irq     (irq),
        .rx      (rx),
        .tx      (tx)
    );

    // Line level of bit k (0..9) of an 8N1 frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk_bus);
        addr  = a;
        wdata = d;
        write = 1'b1;
        @(negedge clk_bus);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk_bus);
        addr = a;
        read = 1'b1;
        #1;
        d = rdata;
        @(negedge clk_bus);
        read = 1'b0;
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop, input int div);
        @(negedge clk_bus);
        for (int k = 0; k < 10; k++) begin
            rx_tb = (k == 9) ? stop : frame_bit(b, k);
            repeat (div + 1) @(negedge clk_bus);
        end
        rx_tb = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int errs;
        rst_bus = 1'b0; addr = 16'h0; wdata = 16'h0; write = 1'b0; read = 1'b0;
        rx_tb = 1'b1; loop_en = 1'b0;
        repeat (3) @(posedge clk_bus);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        @(negedge clk_bus);
        rst_bus = 1'b1;
        bus_write(A_DATA, 16'($urandom_range(0, 255)));
        bus_write(A_DATA, 16'($urandom_range(0, 255)));
        repeat (5) @(posedge clk_bus);
        #1;
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL start_bit_before_reset got %b want 0", tx); end
        #2;
        rst_bus = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx got %b want 1", tx); end
        repeat (2) @(negedge clk_bus);
        rst_bus = 1'b1;
        errs = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_bus);
            #1;
            if (tx !== 1'b1) errs++;
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL fifo_lost_tx_idle low_cycles=%0d want 0", errs); end
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 16'h0006) begin n_fail++; $display("FAIL reset_status got %h want 0006", d); end
        bus_read(A_DIV, d);
        n_checks++;
        if (d !== 16'd433) begin n_fail++; $display("FAIL reset_div got %0d want 433", d); end
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl got %h want 0000", d); end
        bus_read(16'h1235, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL miss_addr_rdata got %h want 0000", d); end
        #1;
        n_checks++;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL idle_rdata got %h want 0000", rdata); end
    endtask

    task automatic test_div_ctrl_regs();
        logic [15:0] v, d;
        v = 16'($urandom);
        bus_write(A_DIV, v);
        bus_read(A_DIV, d);
        n_checks++;
        if (d !== v) begin n_fail++; $display("FAIL div_readback got %h want %h", d, v); end
        bus_write(A_CTRL, 16'hFFFC);
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL ctrl_mask got %h want 0000", d); end
        bus_write(A_STAT, 16'hFFFF);
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 16'h0006) begin n_fail++; $display("FAIL status_ro got %h want 0006", d); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] b;
        int div, len;
        logic exp_tx, exp_busy;
        for (int t = 0; t < 4; t++) begin
            div = (t == 0) ? 3 : int'($urandom_range(3, 6));
            b   = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            len = 10 * (div + 1);
            bus_write(A_DIV, 16'(div));
            bus_write(A_DATA, {8'h00, b});
            addr = A_STAT;
            read = 1'b1;
            for (int k = 1; k <= len + 1; k++) begin
                @(posedge clk_bus);
                #1;
                exp_tx   = (k <= len) ? frame_bit(b, (k - 1) / (div + 1)) : 1'b1;
                exp_busy = (k <= len);
                n_checks++;
                if (tx !== exp_tx) begin
                    n_fail++;
                    $display("FAIL tx_frame byte=%h div=%0d cycle=%0d tx=%b want %b", b, div, k, tx, exp_tx);
                end
                n_checks++;
                if (rdata[5] !== exp_busy) begin
                    n_fail++;
                    $display("FAIL tx_busy byte=%h cycle=%0d got %b want %b", b, k, rdata[5], exp_busy);
                end
            end
            read = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [10];
        logic [15:0] d;
        int errs;
        for (int i = 0; i < 10; i++) b[i] = 8'($urandom_range(0, 255));
        bus_write(A_DIV, 16'd3);
        bus_write(A_DATA, {8'h00, b[0]});
        errs = 0;
        fork
            begin
                logic exp;
                for (int k = 1; k <= 361; k++) begin
                    @(posedge clk_bus);
                    #1;
                    exp = (k <= 360) ? frame_bit(b[(k - 1) / 40], ((k - 1) % 40) / 4) : 1'b1;
                    if (tx !== exp) begin
                        errs++;
                        if (errs < 5) $display("FAIL b2b_stream cycle=%0d tx=%b want %b", k, tx, exp);
                    end
                end
            end
            begin
                for (int i = 1; i <= 9; i++) begin
                    @(negedge clk_bus);
                    addr  = A_DATA;
                    wdata = {8'h00, b[i]};
                    write = 1'b1;
                end
                @(negedge clk_bus);
                write = 1'b0;
            end
        join
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL b2b_frames bad_cycles=%0d want 0", errs); end
        bus_read(A_STAT, d);
        n_checks++;
        if (d[7] !== 1'b1) begin n_fail++; $display("FAIL txovf_set got %b want 1", d[7]); end
        n_checks++;
        if (d[1] !== 1'b1) begin n_fail++; $display("FAIL tx_drained got %b want 1", d[1]); end
        bus_write(A_STAT, 16'h0080);
        bus_read(A_STAT, d);
        n_checks++;
        if (d[7] !== 1'b0) begin n_fail++; $display("FAIL txovf_clear got %b want 0", d[7]); end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        logic [15:0] d;
        logic found;
        bus_write(A_DIV, 16'd3);
        loop_en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            v = (t == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            bus_write(A_DATA, {8'h00, v});
            addr  = A_STAT;
            read  = 1'b1;
            found = 1'b0;
            for (int c = 0; c < 200 && !found; c++) begin
                @(posedge clk_bus);
                #1;
                if (rdata[2] === 1'b0) found = 1'b1;
            end
            read = 1'b0;
            n_checks++;
            if (!found) begin n_fail++; $display("FAIL loop_rx_arrive got timeout want byte %h", v); end
            bus_read(A_DATA, d);
            n_checks++;
            if (d !== {8'h00, v}) begin n_fail++; $display("FAIL loop_data got %h want %h", d, v); end
            bus_read(A_STAT, d);
            n_checks++;
            if (d[2] !== 1'b1) begin n_fail++; $display("FAIL loop_rx_empty got %b want 1", d[2]); end
            bus_read(A_DATA, d);
            n_checks++;
            if (d !== 16'h0000) begin n_fail++; $display("FAIL empty_read got %h want 0000", d); end
            repeat (10) @(negedge clk_bus);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_rx_errors();
        logic [7:0] q [9];
        logic [15:0] d;
        bus_write(A_DIV, 16'd3);
        send_serial(8'($urandom_range(0, 255)), 1'b0, 3);
        repeat (8) @(negedge clk_bus);
        bus_read(A_STAT, d);
        n_checks++;
        if (d[2] !== 1'b1) begin n_fail++; $display("FAIL ferr_no_push rx_empty=%b want 1", d[2]); end
        n_checks++;
        if (d[6] !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", d[6]); end
        bus_write(A_STAT, 16'h0040);
        bus_read(A_STAT, d);
        n_checks++;
        if (d[6] !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b want 0", d[6]); end

        for (int i = 0; i < 9; i++) begin
            q[i] = 8'($urandom_range(0, 255));
            send_serial(q[i], 1'b1, 3);
        end
        repeat (8) @(negedge clk_bus);
        bus_read(A_STAT, d);
        n_checks++;
        if (d[4] !== 1'b1) begin n_fail++; $display("FAIL rxovr_set got %b want 1", d[4]); end
        n_checks++;
        if (d[3] !== 1'b1) begin n_fail++; $display("FAIL rx_full got %b want 1", d[3]); end
        for (int i = 0; i < 8; i++) begin
            bus_read(A_DATA, d);
            n_checks++;
            if (d !== {8'h00, q[i]}) begin n_fail++; $display("FAIL rx_fifo_order idx=%0d got %h want %h", i, d, q[i]); end
        end
        bus_read(A_STAT, d);
        n_checks++;
        if (d[2] !== 1'b1) begin n_fail++; $display("FAIL rx_drained got %b want 1", d[2]); end
        bus_write(A_STAT, 16'h0010);
        bus_read(A_STAT, d);
        n_checks++;
        if (d[4] !== 1'b0) begin n_fail++; $display("FAIL rxovr_clear got %b want 0", d[4]); end

        @(negedge clk_bus);
        rx_tb = 1'b0;
        @(negedge clk_bus);
        rx_tb = 1'b1;
        repeat (40) @(negedge clk_bus);
        bus_read(A_STAT, d);
        n_checks++;
        if (d[2] !== 1'b1) begin n_fail++; $display("FAIL glitch_no_byte rx_empty=%b want 1", d[2]); end
        n_checks++;
        if (d[6] !== 1'b0) begin n_fail++; $display("FAIL glitch_no_ferr got %b want 0", d[6]); end
    endtask

    task automatic test_irq();
        logic [7:0] v;
        logic [15:0] d;
        logic found;
        v = 8'($urandom_range(0, 255));
        bus_write(A_DIV, 16'd3);
        bus_write(A_CTRL, 16'h0001);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_idle got %b want 0", irq); end
        found = 1'b0;
        fork
            send_serial(v, 1'b1, 3);
            begin
                addr = A_STAT;
                read = 1'b1;
                for (int c = 0; c < 200 && !found; c++) begin
                    @(posedge clk_bus);
                    #1;
                    if (rdata[2] === 1'b0) begin
                        found = 1'b1;
                        n_checks++;
                        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got %b want 0", irq); end
                        @(posedge clk_bus);
                        #1;
                        n_checks++;
                        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx_rise got %b want 1", irq); end
                    end
                end
                read = 1'b0;
            end
        join
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL irq_rx_arrive got timeout want byte"); end
        bus_read(A_DATA, d);
        n_checks++;
        if (d !== {8'h00, v}) begin n_fail++; $display("FAIL irq_data got %h want %h", d, v); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_fall_lag got %b want 1", irq); end
        @(posedge clk_bus);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_fall got %b want 0", irq); end
        bus_write(A_CTRL, 16'h0002);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tx_lag got %b want 0", irq); end
        @(posedge clk_bus);
        #1;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx_empty got %b want 1", irq); end
        bus_write(A_CTRL, 16'h0000);
        @(posedge clk_bus);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got %b want 0", irq); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_div_ctrl_regs();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_rx_errors();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
